// File: rtl/pc_sequencer_pkg.sv
// Shared constants for the fetch-stage PC sequencer.
//   - NPCOp selector codes driven by the decode-stage control unit
//   - reset vector, exception handler vector, legal fetch window
//   - helper to classify an illegal fetch address
package pc_sequencer_pkg;

  // Next-PC selector codes. Any other value is treated as sequential fetch.
  localparam logic [7:0] NPC_PC4     = 8'd0;
  localparam logic [7:0] NPC_BRANCH  = 8'd1;
  localparam logic [7:0] NPC_JUMP    = 8'd2;
  localparam logic [7:0] NPC_JUMPREG = 8'd3;

  // Fixed vectors.
  localparam logic [31:0] RESET_VEC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_VEC = 32'h0000_4180;

  // Inclusive legal fetch window (word addresses).
  localparam logic [31:0] FETCH_LO = 32'h0000_3000;
  localparam logic [31:0] FETCH_HI = 32'h0000_6FFC;

  // Misaligned or outside the instruction memory window.
  function automatic logic fetch_addr_bad(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < FETCH_LO) || (pc > FETCH_HI);
  endfunction

endpackage

// File: rtl/pc_sequencer_npc.sv
// npc_calc: purely combinational next-PC target for the instruction in D.
// Ports:
//   pcf_i      current fetch PC (sequential fallback)
//   pcd_i      PC of the D-stage instruction (branch/jump base)
//   npc_op_i   next-PC selector
//   cmp_i      branch taken flag from the D-stage comparator
//   imm16_i    branch offset field
//   imm26_i    jump index field
//   regjump_i  forwarded rs for jr/jalr
//   npc_o      selected target
//   bd_o       1 when the instruction now being fetched sits in a delay slot
module npc_calc
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] pcf_i,
  input  logic [31:0] pcd_i,
  input  logic [7:0]  npc_op_i,
  input  logic        cmp_i,
  input  logic [15:0] imm16_i,
  input  logic [25:0] imm26_i,
  input  logic [31:0] regjump_i,
  output logic [31:0] npc_o,
  output logic        bd_o
);

  logic signed [31:0] br_off;
  logic        [31:0] pc_plus4;
  logic        [31:0] br_target;

  // Word offset, sign-extended and scaled to bytes.
  assign br_off    = {{14{imm16_i[15]}}, imm16_i, 2'b00};
  assign pc_plus4  = pcf_i + 32'd4;
  assign br_target = pcd_i + 32'd4 + $unsigned(br_off);

  always_comb begin
    npc_o = pc_plus4;
    bd_o  = 1'b0;
    case (npc_op_i)
      NPC_BRANCH: begin
        // Delay slot exists whether or not the branch is taken.
        npc_o = cmp_i ? br_target : pc_plus4;
        bd_o  = 1'b1;
      end
      NPC_JUMP: begin
        npc_o = {pcd_i[31:28], imm26_i, 2'b00};
        bd_o  = 1'b1;
      end
      NPC_JUMPREG: begin
        // No alignment masking: a bad rs surfaces as a fetch exception.
        npc_o = regjump_i;
        bd_o  = 1'b1;
      end
      default: begin
        // NPC_PC4 and undefined codes: plain sequential fetch, no delay slot.
        npc_o = pc_plus4;
        bd_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC register with redirect precedence
//   reset > Req > Stall > Eret > NPCOp.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   Stall        hold F and D
//   NPCOp        next-PC selector for D
//   CMPOut       branch taken flag
//   PCD          PC of D instruction
//   Imm16, Imm26 branch offset / jump index of D instruction
//   RegJump      forwarded rs for register jumps
//   Req          exception/interrupt redirect from CP0
//   Eret         eret in D
//   EPC          eret return address
//   PCF          registered fetch address
//   BDF          registered delay-slot flag for the instruction at PCF
//   ExcAdELF     combinational fetch address error
module pc_sequencer
  import pc_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic [7:0]  NPCOp,
  input  logic        CMPOut,
  input  logic [31:0] PCD,
  input  logic [15:0] Imm16,
  input  logic [25:0] Imm26,
  input  logic [31:0] RegJump,
  input  logic        Req,
  input  logic        Eret,
  input  logic [31:0] EPC,
  output logic [31:0] PCF,
  output logic        BDF,
  output logic        ExcAdELF
);

  logic [31:0] pcf_q, pcf_d;
  logic        bdf_q, bdf_d;
  logic [31:0] npc;
  logic        npc_bd;

  npc_calc u_npc_calc (
    .pcf_i     (pcf_q),
    .pcd_i     (PCD),
    .npc_op_i  (NPCOp),
    .cmp_i     (CMPOut),
    .imm16_i   (Imm16),
    .imm26_i   (Imm26),
    .regjump_i (RegJump),
    .npc_o     (npc),
    .bd_o      (npc_bd)
  );

  // Precedence below reset; Req wins even over a stall so an exception is
  // never lost behind a hazard freeze.
  always_comb begin
    pcf_d = pcf_q;
    bdf_d = bdf_q;
    if (Req) begin
      pcf_d = HANDLER_VEC;
      bdf_d = 1'b0;
    end else if (!Stall) begin
      if (Eret) begin
        pcf_d = EPC;
        bdf_d = 1'b0;
      end else begin
        pcf_d = npc;
        bdf_d = npc_bd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcf_q <= RESET_VEC;
      bdf_q <= 1'b0;
    end else begin
      pcf_q <= pcf_d;
      bdf_q <= bdf_d;
    end
  end

  assign PCF      = pcf_q;
  assign BDF      = bdf_q;
  assign ExcAdELF = fetch_addr_bad(pcf_q);

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, Stall, CMPOut, Req, Eret;
  logic [7:0]  NPCOp;
  logic [31:0] PCD, RegJump, EPC;
  logic [15:0] Imm16;
  logic [25:0] Imm26;
  logic [31:0] PCF;
  logic        BDF, ExcAdELF;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .Stall    (Stall),
    .NPCOp    (NPCOp),
    .CMPOut   (CMPOut),
    .PCD      (PCD),
    .Imm16    (Imm16),
    .Imm26    (Imm26),
    .RegJump  (RegJump),
    .Req      (Req),
    .Eret     (Eret),
    .EPC      (EPC),
    .PCF      (PCF),
    .BDF      (BDF),
    .ExcAdELF (ExcAdELF)
  );

  typedef struct {
    string       name;
    logic        rst, req, stall, eret, cmp;
    logic [7:0]  op;
    logic [31:0] pcd;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] rj, epc;
    logic [31:0] exp_pc;
    logic        exp_bd, exp_exc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic rst, input logic req, input logic stall,
                     input logic eret, input logic [7:0] op, input logic cmp,
                     input logic [31:0] pcd, input logic [15:0] i16, input logic [25:0] i26,
                     input logic [31:0] rj, input logic [31:0] epc,
                     input logic [31:0] epc_exp, input logic ebd, input logic eexc);
    vec_t v;
    v.name = nm; v.rst = rst; v.req = req; v.stall = stall; v.eret = eret; v.op = op;
    v.cmp = cmp; v.pcd = pcd; v.imm16 = i16; v.imm26 = i26; v.rj = rj; v.epc = epc;
    v.exp_pc = epc_exp; v.exp_bd = ebd; v.exp_exc = eexc;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic req, input logic stall, input logic eret,
                       input logic [7:0] op, input logic cmp, input logic [31:0] pcd,
                       input logic [15:0] i16, input logic [25:0] i26,
                       input logic [31:0] rj, input logic [31:0] epc);
    reset = rst; Req = req; Stall = stall; Eret = eret; NPCOp = op; CMPOut = cmp;
    PCD = pcd; Imm16 = i16; Imm26 = i26; RegJump = rj; EPC = epc;
  endtask

  task automatic check(input string nm, input logic [31:0] e_pc, input logic e_bd,
                       input logic e_exc);
    n_total++;
    if (PCF === e_pc) n_pass++;
    else $display("FAIL %s PCF: got %08h expected %08h", nm, PCF, e_pc);
    n_total++;
    if (BDF === e_bd) n_pass++;
    else $display("FAIL %s BDF: got %0b expected %0b", nm, BDF, e_bd);
    n_total++;
    if (ExcAdELF === e_exc) n_pass++;
    else $display("FAIL %s ExcAdELF: got %0b expected %0b", nm, ExcAdELF, e_exc);
  endtask

  // Reference model state, driven from the architectural rules.
  logic [31:0] m_pc;
  logic        m_bd;

  function automatic logic m_exc(input logic [31:0] pc);
    longint unsigned a;
    a = pc;
    return (a % 4 != 0) || (a < 64'h3000) || (a > 64'h6FFC);
  endfunction

  task automatic model_step(input logic rst, input logic req, input logic stall,
                            input logic eret, input logic [7:0] op, input logic cmp,
                            input logic [31:0] pcd, input logic [15:0] i16,
                            input logic [25:0] i26, input logic [31:0] rj,
                            input logic [31:0] epc);
    longint signed off;
    longint unsigned tgt;
    if (rst) begin
      m_pc = 32'h3000; m_bd = 1'b0;
    end else if (req) begin
      m_pc = 32'h4180; m_bd = 1'b0;
    end else if (stall) begin
      // hold
    end else if (eret) begin
      m_pc = epc; m_bd = 1'b0;
    end else if (op == 8'd1) begin
      m_bd = 1'b1;
      if (cmp) begin
        off = longint'($signed(i16)) * 4;
        tgt = longint'(pcd) + 4 + off;
        m_pc = tgt[31:0];
      end else begin
        tgt = longint'(m_pc) + 4;
        m_pc = tgt[31:0];
      end
    end else if (op == 8'd2) begin
      m_bd = 1'b1;
      m_pc = (pcd & 32'hF000_0000) | (32'(i26) * 4);
    end else if (op == 8'd3) begin
      m_bd = 1'b1;
      m_pc = rj;
    end else begin
      m_bd = 1'b0;
      tgt = longint'(m_pc) + 4;
      m_pc = tgt[31:0];
    end
  endtask

  initial begin
    //  name          rst req stl ert op     cmp pcd           imm16     imm26        regjump       epc           exp_pc        bd exc
    add("rst",        1,  0,  0,  0,  8'd0,  0,  32'h0,        16'h0,    26'h0,       32'h0,        32'h0,        32'h3000,     0, 0);
    add("pc4_a",      0,  0,  0,  0,  8'd0,  0,  32'h0,        16'h0,    26'h0,       32'h0,        32'h0,        32'h3004,     0, 0);
    add("pc4_b",      0,  0,  0,  0,  8'd0,  0,  32'h0,        16'h0,    26'h0,       32'h0,        32'h0,        32'h3008,     0, 0);
    add("pc4_c",      0,  0,  0,  0,  8'd0,  0,  32'h0,        16'h0,    26'h0,       32'h0,        32'h0,        32'h300C,     0, 0);
    add("br_taken",   0,  0,  0,  0,  8'd1,  1,  32'h3010,     16'hFFFC, 26'h0,       32'h0,        32'h0,        32'h3004,     1, 0);
    add("br_nt",      0,  0,  0,  0,  8'd1,  0,  32'h3010,     16'hFFFC, 26'h0,       32'h0,        32'h0,        32'h3008,     1, 0);
    add("stall_hold", 0,  0,  1,  0,  8'd0,  0,  32'h0,        16'h0,    26'h0,       32'h0,        32'h0,        32'h3008,     1, 0);
    add("stall_req",  0,  1,  1,  0,  8'd2,  0,  32'h3000,     16'h0,    26'h123,     32'h0,        32'h0,        32'h4180,     0, 0);
    add("eret_jump",  0,  0,  0,  1,  8'd2,  0,  32'h3000,     16'h0,    26'h0C40,    32'h0,        32'h3020,     32'h3020,     0, 0);
    add("jr_3002",    0,  0,  0,  0,  8'd3,  0,  32'h0,        16'h0,    26'h0,       32'h3002,     32'h0,        32'h3002,     1, 1);
    add("jr_7000",    0,  0,  0,  0,  8'd3,  0,  32'h0,        16'h0,    26'h0,       32'h7000,     32'h0,        32'h7000,     1, 1);
    add("jr_6ffc",    0,  0,  0,  0,  8'd3,  0,  32'h0,        16'h0,    26'h0,       32'h6FFC,     32'h0,        32'h6FFC,     1, 0);
    add("jr_2ffc",    0,  0,  0,  0,  8'd3,  0,  32'h0,        16'h0,    26'h0,       32'h2FFC,     32'h0,        32'h2FFC,     1, 1);
    add("jump",       0,  0,  0,  0,  8'd2,  0,  32'hA000_3010, 16'h0,   26'h0C40,    32'h0,        32'h0,        32'hA000_3100, 1, 1);
    add("undef_op",   0,  0,  0,  0,  8'h55, 1,  32'h0,        16'h0010, 26'h0,       32'h0,        32'h0,        32'hA000_3104, 0, 1);
    add("jr_5000",    0,  0,  0,  0,  8'd3,  0,  32'h0,        16'h0,    26'h0,       32'h5000,     32'h0,        32'h5000,     1, 0);
    add("rst_req",    1,  1,  0,  1,  8'd3,  1,  32'h0,        16'h0,    26'h0,       32'h5000,     32'h4000,     32'h3000,     0, 0);
    add("jr_top",     0,  0,  0,  0,  8'd3,  0,  32'h0,        16'h0,    26'h0,       32'hFFFF_FFFC, 32'h0,       32'hFFFF_FFFC, 1, 1);
    add("pc4_wrap",   0,  0,  0,  0,  8'd0,  0,  32'h0,        16'h0,    26'h0,       32'h0,        32'h0,        32'h0,        0, 1);
    add("br_fwd",     0,  0,  0,  0,  8'd1,  1,  32'h4000,     16'h0010, 26'h0,       32'h0,        32'h0,        32'h4044,     1, 0);
    add("rst_stall",  1,  0,  1,  0,  8'd1,  1,  32'h0,        16'h0,    26'h0,       32'h0,        32'h0,        32'h3000,     0, 0);

    drive(1, 0, 0, 0, 8'd0, 0, 0, 0, 0, 0, 0);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].stall, vecs[i].eret, vecs[i].op, vecs[i].cmp,
            vecs[i].pcd, vecs[i].imm16, vecs[i].imm26, vecs[i].rj, vecs[i].epc);
      @(posedge clk);
      #1;
      check(vecs[i].name, vecs[i].exp_pc, vecs[i].exp_bd, vecs[i].exp_exc);
    end

    // Randomized phase against the reference model; last table entry left
    // the DUT at the reset vector.
    m_pc = 32'h3000;
    m_bd = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic        r_rst, r_req, r_stl, r_ert, r_cmp;
      logic [7:0]  r_op;
      logic [31:0] r_pcd, r_rj, r_epc;
      logic [15:0] r_i16;
      logic [25:0] r_i26;
      int sel;
      r_rst = ($urandom_range(0, 39) == 0);
      r_req = ($urandom_range(0, 19) == 0);
      r_stl = ($urandom_range(0, 4) == 0);
      r_ert = ($urandom_range(0, 9) == 0);
      r_cmp = 1'($urandom_range(0, 1));
      sel   = $urandom_range(0, 9);
      r_op  = (sel < 4) ? 8'(sel) : (sel < 6 ? 8'($urandom) : 8'd0);
      r_pcd = (sel == 9) ? $urandom : 32'h3000 + ($urandom_range(0, 32'h3FFF) & 32'hFFFC);
      r_i16 = 16'($urandom);
      r_i26 = 26'($urandom);
      r_rj  = ($urandom_range(0, 3) == 0) ? $urandom : 32'h2FF0 + $urandom_range(0, 32'h4020);
      r_epc = 32'h3000 + $urandom_range(0, 32'h4000);
      drive(r_rst, r_req, r_stl, r_ert, r_op, r_cmp, r_pcd, r_i16, r_i26, r_rj, r_epc);
      model_step(r_rst, r_req, r_stl, r_ert, r_op, r_cmp, r_pcd, r_i16, r_i26, r_rj, r_epc);
      @(posedge clk);
      #1;
      check($sformatf("rand%0d", i), m_pc, m_bd, m_exc(m_pc));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
